// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the video PLL reset/lock sequencer.
// Holds the sequencer state encoding, the retry counter width and the counter-width helper.
// No logic; imported by pll_reset_seq.
package pll_seq_pkg;

    // Failed-attempt counter width and its saturation value
    localparam int RETRY_W   = 3;
    localparam int RETRY_MAX = (1 << RETRY_W) - 1;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_e;

    // One shared counter covers every timed state, so size it for the longest interval
    function automatic int cnt_width(input int rst_cycles, input int lock_timeout,
                                     input int settle_cycles);
        int m;
        m = rst_cycles;
        if (lock_timeout > m)  m = lock_timeout;
        if (settle_cycles > m) m = settle_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous level signals.
// Latency: 2 clk edges from input change to q_o.
// No backpressure; samples every cycle, resets to all-zero.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First stage may go metastable; second stage gives it a full cycle to resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// Reset/lock sequencer for the video PLL, running on the 50 MHz reference clock.
// Latency: pll_locked is seen 2 edges late; all outputs are registered from next state.
// No backpressure; optional lock-loss counter enabled by PLL_RESET_SEQ_LOSS_CNT_EN.
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               req_reset,
    output logic               pll_rst,
    output logic               sys_rst_n,
    output logic               lock_ok,
    output logic               pll_fail,
    output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    ,
    output logic [7:0]         loss_cnt
`endif
);

    localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);

    // Terminal counter values. The WAIT_LOCK cycle that first sees locked_s=1 is the
    // first of the SETTLE_CYCLES stable samples, so SETTLE itself ends one count early.
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES >= 2) ? (SETTLE_CYCLES - 2) : 0);
    localparam bit               SETTLE_SKIP = (SETTLE_CYCLES <= 1);

    // A limit above the saturation value can never be reached and behaves as retry-forever
    localparam bit                 RETRY_LIMITED = (MAX_RETRIES != 0) && (MAX_RETRIES <= RETRY_MAX);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT   = RETRY_W'(RETRY_LIMITED ? MAX_RETRIES : RETRY_MAX);

    pll_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [RETRY_W-1:0] retry_inc;
    pll_state_e         fail_dst;
    logic               pll_rst_q, sys_rst_n_q, lock_ok_q, pll_fail_q;
    logic               locked_s;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    // Outcome of a failed attempt: bump the saturating retry count and pick HOLD or FAIL
    always_comb begin
        retry_inc = (retry_q == RETRY_W'(RETRY_MAX)) ? retry_q : retry_q + 1'b1;
        fail_dst  = (RETRY_LIMITED && (retry_inc >= RETRY_LIMIT)) ? ST_FAIL : ST_HOLD;
    end

    // Next-state logic; req_reset overrides every other event, counter clears on state entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        case (state_q)
            ST_HOLD: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = SETTLE_SKIP ? ST_RUN : ST_SETTLE;
                end else if (cnt_q == TMO_LAST) begin
                    retry_d = retry_inc;
                    state_d = fail_dst;
                end
            end
            ST_SETTLE: begin
                if (!locked_s) begin
                    retry_d = retry_inc;
                    state_d = fail_dst;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q;
                if (!locked_s) begin
                    retry_d = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_FAIL: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
        if (req_reset) begin
            state_d = ST_HOLD;
            retry_d = '0;
        end
        if ((state_d != state_q) || req_reset) cnt_d = '0;
    end

    // State, counter and retry registers
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // Outputs decoded from next state so they change on the same edge as the state
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            lock_ok_q   <= 1'b0;
            pll_fail_q  <= 1'b0;
        end else begin
            pll_rst_q   <= (state_d == ST_HOLD) || (state_d == ST_FAIL);
            sys_rst_n_q <= (state_d == ST_RUN);
            lock_ok_q   <= (state_d == ST_RUN);
            pll_fail_q  <= (state_d == ST_FAIL);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign lock_ok   = lock_ok_q;
    assign pll_fail  = pll_fail_q;
    assign retry_cnt = retry_q;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    logic [7:0] loss_q;
    logic       loss_evt;

    // A genuine RUN->HOLD lock loss; a simultaneous req_reset takes precedence and is not counted
    assign loss_evt = (state_q == ST_RUN) && !locked_s && !req_reset;

    // Saturating lock-loss history, survives req_reset so software can read it afterwards
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (loss_evt && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with small timing parameters.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Expected values are hand-computed edge counts from the sequencer's behaviour.
module tb_pll_reset_seq;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       req_reset;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       lock_ok;
    logic       pll_fail;
    logic [2:0] retry_cnt;
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 refclk = ~refclk;

    pll_reset_seq #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .SETTLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .req_reset  (req_reset),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .lock_ok    (lock_ok),
        .pll_fail   (pll_fail),
        .retry_cnt  (retry_cnt)
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
        ,
        .loss_cnt   (loss_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        req_reset  = 1'b0;
        #23;
        chk("rst_pll_rst",   pll_rst,   1);
        chk("rst_sys_rst_n", sys_rst_n, 0);
        chk("rst_lock_ok",   lock_ok,   0);
        chk("rst_pll_fail",  pll_fail,  0);
        chk("rst_retry",     retry_cnt, 0);
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
        chk("rst_loss_cnt",  loss_cnt,  0);
`endif

        // Normal bring-up: HOLD for 4 edges, lock at cycle 10, release 2+8 edges later
        @(posedge refclk);
        #1;
        rst_n = 1'b1;
        tick(3);
        chk("hold_3_pll_rst", pll_rst, 1);
        tick(1);
        chk("hold_4_pll_rst", pll_rst, 0);
        tick(5);
        pll_locked = 1'b1;
        tick(9);
        chk("lock_9_sys_rst_n", sys_rst_n, 0);
        chk("lock_9_lock_ok",   lock_ok,   0);
        tick(1);
        chk("lock_10_sys_rst_n", sys_rst_n, 1);
        chk("lock_10_lock_ok",   lock_ok,   1);
        chk("lock_10_retry",     retry_cnt, 0);
        chk("lock_10_pll_rst",   pll_rst,   0);

        // One-cycle lock drop in RUN: reset reasserts on the third edge
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        chk("loss_2_sys_rst_n", sys_rst_n, 1);
        tick(1);
        chk("loss_3_sys_rst_n", sys_rst_n, 0);
        chk("loss_3_lock_ok",   lock_ok,   0);
        chk("loss_3_pll_rst",   pll_rst,   1);
        chk("loss_3_retry",     retry_cnt, 0);
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
        chk("loss_3_loss_cnt",  loss_cnt,  1);
`endif

        // Re-sequence, then lose lock while SETTLE count is 5
        tick(4);
        chk("reseq_wait_pll_rst", pll_rst, 0);
        tick(4);
        pll_locked = 1'b0;
        tick(2);
        chk("settle_pre_pll_rst",   pll_rst,   0);
        chk("settle_pre_sys_rst_n", sys_rst_n, 0);
        tick(1);
        chk("settle_drop_pll_rst",   pll_rst,   1);
        chk("settle_drop_retry",     retry_cnt, 1);
        chk("settle_drop_sys_rst_n", sys_rst_n, 0);
        chk("settle_drop_pll_fail",  pll_fail,  0);

        // Clear, then two 20-cycle timeouts lead to FAIL
        req_reset = 1'b1;
        tick(1);
        req_reset = 1'b0;
        chk("req_clr_retry",   retry_cnt, 0);
        chk("req_clr_pll_rst", pll_rst,   1);
        tick(4);
        chk("tmo1_wait_pll_rst", pll_rst, 0);
        tick(19);
        chk("tmo1_pre_retry",   retry_cnt, 0);
        chk("tmo1_pre_pll_rst", pll_rst,   0);
        tick(1);
        chk("tmo1_retry",    retry_cnt, 1);
        chk("tmo1_pll_rst",  pll_rst,   1);
        chk("tmo1_pll_fail", pll_fail,  0);
        tick(23);
        chk("tmo2_pre_pll_fail", pll_fail, 0);
        tick(1);
        chk("fail_pll_fail",  pll_fail,  1);
        chk("fail_pll_rst",   pll_rst,   1);
        chk("fail_retry",     retry_cnt, 2);
        chk("fail_sys_rst_n", sys_rst_n, 0);
        tick(100);
        chk("fail_hold_pll_fail", pll_fail,  1);
        chk("fail_hold_retry",    retry_cnt, 2);

        // Software request leaves FAIL
        req_reset = 1'b1;
        tick(1);
        req_reset = 1'b0;
        chk("unfail_pll_fail", pll_fail,  0);
        chk("unfail_retry",    retry_cnt, 0);
        chk("unfail_pll_rst",  pll_rst,   1);

        // req_reset coinciding with the second timeout wins over FAIL
        tick(24);
        chk("coin_tmo1_retry", retry_cnt, 1);
        tick(23);
        chk("coin_pre_pll_fail", pll_fail, 0);
        req_reset = 1'b1;
        tick(1);
        req_reset = 1'b0;
        chk("coin_pll_fail", pll_fail,  0);
        chk("coin_retry",    retry_cnt, 0);
        chk("coin_pll_rst",  pll_rst,   1);
        tick(4);
        chk("coin_wait_pll_rst", pll_rst, 0);

        // Async reset mid-WAIT_LOCK, between edges, after one timeout
        tick(26);
        chk("arst_pre_pll_rst", pll_rst,   0);
        chk("arst_pre_retry",   retry_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pll_rst",   pll_rst,   1);
        chk("arst_sys_rst_n", sys_rst_n, 0);
        chk("arst_retry",     retry_cnt, 0);
        #2;
        rst_n      = 1'b1;
        pll_locked = 1'b1;
        tick(3);
        chk("arst_hold_3_pll_rst", pll_rst, 1);
        tick(1);
        chk("arst_hold_4_pll_rst", pll_rst, 0);
        tick(7);
        chk("arst_run_pre_sys_rst_n", sys_rst_n, 0);
        tick(1);
        chk("arst_run_sys_rst_n", sys_rst_n, 1);
        chk("arst_run_lock_ok",   lock_ok,   1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
